// File: rtl/frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_streamer
//  Description : Streams fixed-length frames out of a writable pattern memory,
//                with button/timer pattern advance at frame boundaries and
//                capture of a downstream classifier result.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_streamer #(
    parameter int DATA_W         = 8,
    parameter int FRAME_LEN      = 32,
    parameter int NUM_PATTERNS   = 4,
    parameter int CAPTURE_OFFSET = 1,
    parameter int RES_W          = 8,
    parameter int TIMER_MAX      = 12000000
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      continuous,
    input  logic                                      next_btn,
    input  logic                                      auto_en,
    input  logic                                      wr_en,
    input  logic [$clog2(NUM_PATTERNS*FRAME_LEN)-1:0] wr_addr,
    input  logic [DATA_W-1:0]                         wr_data,
    input  logic [3:0]                                res_index,
    input  logic [RES_W-1:0]                          res_value,
    output logic [DATA_W-1:0]                         data_out,
    output logic                                      data_valid,
    output logic [$clog2(FRAME_LEN)-1:0]              byte_idx,
    output logic [$clog2(NUM_PATTERNS)-1:0]           pattern_sel,
    output logic [3:0]                                cap_index,
    output logic [RES_W-1:0]                          cap_value,
    output logic                                      cap_valid,
    output logic                                      busy
);

    localparam int c_DEPTH  = NUM_PATTERNS * FRAME_LEN;
    localparam int c_ADDR_W = $clog2(c_DEPTH);
    localparam int c_IDX_W  = $clog2(FRAME_LEN);
    localparam int c_SEL_W  = $clog2(NUM_PATTERNS);
    localparam int c_TMR_W  = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(FRAME_LEN - 1);
    localparam logic [c_IDX_W-1:0] c_CAP_IDX  = c_IDX_W'(CAPTURE_OFFSET);
    localparam logic [c_SEL_W-1:0] c_SEL_LAST = c_SEL_W'(NUM_PATTERNS - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMER_MAX - 1);

    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_STREAM = 1'b1;

    logic [0:0]          r_state;
    logic [c_IDX_W-1:0]  r_cnt;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_pending;
    logic                r_btn_q;
    logic [DATA_W-1:0]   r_mem [0:c_DEPTH-1];
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_s1_vld;
    logic [c_IDX_W-1:0]  r_s1_idx;

    logic                w_btn_rise;
    logic                w_tick;
    logic                w_req;
    logic                w_wrap;
    logic                w_apply;
    logic                w_cap;
    logic [c_ADDR_W-1:0] w_rd_addr;

    assign w_btn_rise = next_btn & ~r_btn_q;
    assign w_tick     = auto_en && (r_timer == c_TMR_LAST);
    assign w_req      = w_btn_rise | w_tick;
    assign w_wrap     = (r_state == c_S_STREAM) && (r_cnt == c_IDX_LAST);
    // Advances land only between frames so a frame never mixes two patterns.
    assign w_apply    = r_pending && ((r_state == c_S_IDLE) || w_wrap);
    assign w_rd_addr  = c_ADDR_W'({pattern_sel, r_cnt});
    assign w_cap      = r_s1_vld && (r_s1_idx == c_CAP_IDX);
    assign busy       = (r_state == c_S_STREAM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_timer     <= '0;
            pattern_sel <= '0;
            r_pending   <= 1'b0;
            r_btn_q     <= 1'b0;
        end else begin
            r_btn_q <= next_btn;

            if (!auto_en || w_tick) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            // A request coinciding with an apply stays pending for the next boundary.
            if (w_apply) begin
                pattern_sel <= (pattern_sel == c_SEL_LAST) ? '0 : pattern_sel + 1'b1;
                r_pending   <= w_req;
            end else if (w_req) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                c_S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_state <= c_S_STREAM;
                    end
                end
                c_S_STREAM: begin
                    r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
                    if (w_wrap && !continuous) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Pattern memory is not reset; a same-address write returns old data here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_idx   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            byte_idx   <= '0;
            cap_index  <= '0;
            cap_value  <= '0;
            cap_valid  <= 1'b0;
        end else begin
            r_s1_vld   <= (r_state == c_S_STREAM);
            r_s1_idx   <= r_cnt;
            data_valid <= r_s1_vld;
            if (r_s1_vld) begin
                data_out <= r_rd_data;
                byte_idx <= r_s1_idx;
            end
            cap_valid <= w_cap;
            if (w_cap) begin
                cap_index <= res_index;
                cap_value <= res_value;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_streamer
//  Description : Directed self-checking bench for frame_streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_streamer;

    localparam int c_DATA_W = 8;
    localparam int c_FL     = 32;
    localparam int c_NP     = 4;
    localparam int c_RES_W  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic        next_btn;
    logic        auto_en;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  res_index;
    logic [7:0]  res_value;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [4:0]  byte_idx;
    logic [1:0]  pattern_sel;
    logic [3:0]  cap_index;
    logic [7:0]  cap_value;
    logic        cap_valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int caps     = 0;

    frame_streamer #(
        .DATA_W         (c_DATA_W),
        .FRAME_LEN      (c_FL),
        .NUM_PATTERNS   (c_NP),
        .CAPTURE_OFFSET (1),
        .RES_W          (c_RES_W),
        .TIMER_MAX      (40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .next_btn    (next_btn),
        .auto_en     (auto_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .res_index   (res_index),
        .res_value   (res_value),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .byte_idx    (byte_idx),
        .pattern_sel (pattern_sel),
        .cap_index   (cap_index),
        .cap_value   (cap_value),
        .cap_valid   (cap_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 7'(a);
        wr_data = 8'(d);
        step();
        wr_en   = 1'b0;
    endtask

    // Leaves the bench sampling just after byte 0 of the first frame appears.
    task automatic start_stream();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_lat0", 32'(data_valid), 32'd0);
        step();
        chk("start_lat1", 32'(data_valid), 32'd0);
        step();
    endtask

    task automatic press();
        next_btn = 1'b1;
        step();
        step();
        next_btn = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; next_btn = 1'b0; auto_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; res_index = '0; res_value = '0;
        repeat (3) step();
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(pattern_sel), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_idx", 32'(byte_idx), 32'd0);
        chk("rst_capv", 32'(cap_valid), 32'd0);
        chk("rst_capi", 32'(cap_index), 32'd0);
        chk("rst_capval", 32'(cap_value), 32'd0);
        rst = 1'b0;
        step();

        // mem[a] = a, so pattern p byte k reads back as p*32+k
        for (int a = 0; a < c_NP * c_FL; a++) wr(a, a);

        // Single frame from pattern 0, result capture on byte 1
        res_index = 4'd7;
        res_value = 8'hA5;
        continuous = 1'b0;
        start_stream();
        for (int k = 0; k < c_FL; k++) begin
            chk($sformatf("t1_valid[%0d]", k), 32'(data_valid), 32'd1);
            chk($sformatf("t1_idx[%0d]", k), 32'(byte_idx), 32'(k));
            chk($sformatf("t1_data[%0d]", k), 32'(data_out), 32'(k));
            chk($sformatf("t1_capv[%0d]", k), 32'(cap_valid), 32'(k == 1));
            if (cap_valid) caps++;
            if (k == 2) begin
                res_index = 4'd3;
                res_value = 8'h00;
            end
            step();
        end
        chk("t1_end_valid", 32'(data_valid), 32'd0);
        chk("t1_end_busy", 32'(busy), 32'd0);
        chk("t1_cap_count", 32'(caps), 32'd1);
        chk("t1_capi_hold", 32'(cap_index), 32'd7);
        chk("t1_capval_hold", 32'(cap_value), 32'hA5);
        chk("t1_capv_low", 32'(cap_valid), 32'd0);

        // Write addr 5 while the read counter sits on 5: old byte now, new next frame
        continuous = 1'b1;
        start_stream();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < c_FL; k++) begin
                wr_en = 1'b0;
                start = 1'b0;
                chk($sformatf("t2_valid[%0d.%0d]", f, k), 32'(data_valid), 32'd1);
                chk($sformatf("t2_idx[%0d.%0d]", f, k), 32'(byte_idx), 32'(k));
                chk($sformatf("t2_data[%0d.%0d]", f, k), 32'(data_out),
                    (f == 1 && k == 5) ? 32'h3C : 32'(k));
                if (f == 0 && k == 3) begin
                    wr_en   = 1'b1;
                    wr_addr = 7'd5;
                    wr_data = 8'h3C;
                end
                if (f == 0 && k == 20) start = 1'b1;
                if (f == 1 && k == 10) continuous = 1'b0;
                step();
            end
        end
        wr_en = 1'b0;
        chk("t2_end_valid", 32'(data_valid), 32'd0);
        wr(5, 5);

        // Button mid-frame (twice): one advance at the frame boundary, no gap
        continuous = 1'b1;
        start_stream();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < c_FL; k++) begin
                chk($sformatf("t3_valid[%0d.%0d]", f, k), 32'(data_valid), 32'd1);
                chk($sformatf("t3_idx[%0d.%0d]", f, k), 32'(byte_idx), 32'(k));
                chk($sformatf("t3_data[%0d.%0d]", f, k), 32'(data_out), 32'(f * 32 + k));
                if (f == 0 && (k == 10 || k == 14)) next_btn = 1'b1;
                if (f == 0 && (k == 12 || k == 16)) next_btn = 1'b0;
                if (f == 1 && k == 10) continuous = 1'b0;
                step();
            end
        end
        chk("t3_end_valid", 32'(data_valid), 32'd0);
        chk("t3_sel", 32'(pattern_sel), 32'd1);

        // Advance in IDLE to pattern 3, then button and timer coincide
        press();
        chk("t4_sel2", 32'(pattern_sel), 32'd2);
        press();
        chk("t4_sel3", 32'(pattern_sel), 32'd3);
        auto_en = 1'b1;
        repeat (39) step();
        next_btn = 1'b1;
        step();
        chk("t4_sel_pending", 32'(pattern_sel), 32'd3);
        step();
        next_btn = 1'b0;
        chk("t4_sel_wrap", 32'(pattern_sel), 32'd0);
        repeat (39) step();
        chk("t4_sel_hold", 32'(pattern_sel), 32'd0);
        step();
        chk("t4_sel_timer", 32'(pattern_sel), 32'd1);
        auto_en = 1'b0;
        step();

        // Reset mid-frame at byte 15 of pattern 1
        continuous = 1'b0;
        start_stream();
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                chk("t5_idx15", 32'(byte_idx), 32'd15);
                chk("t5_data15", 32'(data_out), 32'd47);
            end
            if (k < 15) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_valid", 32'(data_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_sel", 32'(pattern_sel), 32'd0);
        step();
        chk("t5_post_valid", 32'(data_valid), 32'd0);
        start_stream();
        chk("t5_re_valid", 32'(data_valid), 32'd1);
        chk("t5_re_idx", 32'(byte_idx), 32'd0);
        chk("t5_re_data0", 32'(data_out), 32'd0);
        step();
        chk("t5_re_data1", 32'(data_out), 32'd1);
        repeat (40) step();
        chk("t5_re_end", 32'(data_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
